// File: rtl/mem_stage_if.sv
// mem_stage_if: bundles the request handshake, data-memory port and writeback
// handshake of the SIC-4 memory-access stage.
//   req_*  : execute -> stage request (valid/ready)
//   mem_*  : stage -> data_memory (mem_rdata is a combinational read of mem_addr)
//   wb_*   : stage -> writeback load result (valid/ready)
// Modports:
//   slave  : view used by mem_stage
//   master : view used by the surrounding pipeline / memory
interface mem_stage_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TAG_W  = 2
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [TAG_W-1:0]  req_tag;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_data;
  logic [TAG_W-1:0]  wb_tag;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_tag, mem_rdata, wb_ready,
    output req_ready, mem_addr, mem_wdata, mem_we, wb_valid, wb_data, wb_tag
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_tag, mem_rdata, wb_ready,
    input  req_ready, mem_addr, mem_wdata, mem_we, wb_valid, wb_data, wb_tag
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the SIC-4 datapath. Accepts one load or
// store per request handshake, drives data_memory for exactly one cycle per
// request, and holds load data for writeback under a valid/ready handshake.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : mem_stage_if.slave (request, data-memory and writeback signals)
//   ld_count, st_count : 16-bit saturating load/store counters, present only
//                        when MEM_STAGE_STATS_EN is defined
// Optional feature macro: MEM_STAGE_STATS_EN
module mem_stage #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TAG_W  = 2
) (
  input  logic        clk,
  input  logic        rst,
`ifdef MEM_STAGE_STATS_EN
  output logic [15:0] ld_count,
  output logic [15:0] st_count,
`endif
  mem_stage_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StResult} state_e;

  state_e            state_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [TAG_W-1:0]  wb_tag_q;

  logic req_ready;
  logic accept;

  // A store frees the stage during its own ACCESS cycle; a load must first
  // hand its result to writeback.
  always_comb begin
    req_ready = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StIdle:   req_ready = 1'b1;
        StAccess: req_ready = we_q;
        StResult: req_ready = bus.wb_ready;
        default:  req_ready = 1'b0;
      endcase
    end
  end

  assign accept = bus.req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tag_q     <= '0;
      wb_data_q <= '0;
      wb_tag_q  <= '0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        tag_q   <= bus.req_tag;
      end
      unique case (state_q)
        StIdle: begin
          if (accept) state_q <= StAccess;
        end
        StAccess: begin
          if (we_q) begin
            state_q <= accept ? StAccess : StIdle;
          end else begin
            state_q   <= StResult;
            wb_data_q <= bus.mem_rdata;
            wb_tag_q  <= tag_q;
          end
        end
        StResult: begin
          if (bus.wb_ready) state_q <= accept ? StAccess : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready = req_ready;
  // Decoded from registers only, so an async reset drops the write strobe at once.
  assign bus.mem_we    = (state_q == StAccess) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.wb_valid  = (state_q == StResult);
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_tag    = wb_tag_q;

`ifdef MEM_STAGE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_count <= '0;
      st_count <= '0;
    end else if (state_q == StAccess) begin
      if (we_q) begin
        if (st_count != 16'hFFFF) st_count <= st_count + 16'd1;
      end else begin
        if (ld_count != 16'hFFFF) ld_count <= ld_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage with a behavioural
// 256-byte data memory (initial content: addr ^ 0xA5).
module tb_mem_stage;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [7:0] mem_model [256];

`ifdef MEM_STAGE_STATS_EN
  logic [15:0] ld_count;
  logic [15:0] st_count;
`endif

  mem_stage_if #(.ADDR_W(8), .DATA_W(8), .TAG_W(2)) bus ();

  mem_stage #(.ADDR_W(8), .DATA_W(8), .TAG_W(2)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef MEM_STAGE_STATS_EN
    .ld_count (ld_count),
    .st_count (st_count),
`endif
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = mem_model[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_we) mem_model[bus.mem_addr] <= bus.mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic we, input logic [7:0] a,
                       input logic [7:0] d, input logic [1:0] t);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_tag   = t;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) mem_model[i] = 8'(i) ^ 8'hA5;
    rst          = 1'b1;
    bus.wb_ready = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0);
    repeat (2) step();

    // Reset state
    mid();
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_mem_we",    32'(bus.mem_we),    32'd0);
    check_eq("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    check_eq("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check_eq("rst_wb_valid",  32'(bus.wb_valid),  32'd0);
    check_eq("rst_wb_data",   32'(bus.wb_data),   32'd0);
    check_eq("rst_wb_tag",    32'(bus.wb_tag),    32'd0);
`ifdef MEM_STAGE_STATS_EN
    check_eq("rst_ld_count", 32'(ld_count), 32'd0);
    check_eq("rst_st_count", 32'(st_count), 32'd0);
`endif
    step();
    rst = 1'b0;
    mid();
    check_eq("post_rst_ready", 32'(bus.req_ready), 32'd1);

    // Store 0xDE @ 0x55, then load 0x55 tag 2
    step();
    drive(1'b1, 1'b1, 8'h55, 8'hDE, 2'd0);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0);
    mid();
    check_eq("st_mem_we",    32'(bus.mem_we),    32'd1);
    check_eq("st_mem_addr",  32'(bus.mem_addr),  32'h55);
    check_eq("st_mem_wdata", 32'(bus.mem_wdata), 32'hDE);
    check_eq("st_no_wb",     32'(bus.wb_valid),  32'd0);
    step();
    mid();
    check_eq("st_we_once",   32'(bus.mem_we),     32'd0);
    check_eq("st_committed", 32'(mem_model[8'h55]), 32'hDE);
    check_eq("st_no_wb2",    32'(bus.wb_valid),   32'd0);
    step();
    drive(1'b1, 1'b0, 8'h55, 8'h00, 2'd2);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0);
    mid();
    check_eq("ld_acc_we",    32'(bus.mem_we),    32'd0);
    check_eq("ld_acc_ready", 32'(bus.req_ready), 32'd0);
    check_eq("ld_acc_valid", 32'(bus.wb_valid),  32'd0);
    step();
    mid();
    check_eq("ld_wb_valid", 32'(bus.wb_valid), 32'd1);
    check_eq("ld_wb_data",  32'(bus.wb_data),  32'hDE);
    check_eq("ld_wb_tag",   32'(bus.wb_tag),   32'd2);
    step();
    mid();
    check_eq("ld_consumed", 32'(bus.wb_valid), 32'd0);

    // Back-to-back store 0x1F @ 0x02 then load 0x02
    step();
    drive(1'b1, 1'b1, 8'h02, 8'h1F, 2'd0);
    step();
    drive(1'b1, 1'b0, 8'h02, 8'h1F, 2'd1);
    mid();
    check_eq("b2b_st_ready", 32'(bus.req_ready), 32'd1);
    check_eq("b2b_st_we",    32'(bus.mem_we),    32'd1);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0);
    mid();
    check_eq("b2b_ld_we",   32'(bus.mem_we),   32'd0);
    check_eq("b2b_ld_addr", 32'(bus.mem_addr), 32'h02);
    step();
    mid();
    check_eq("b2b_wb_valid", 32'(bus.wb_valid), 32'd1);
    check_eq("b2b_wb_data",  32'(bus.wb_data),  32'h1F);
    check_eq("b2b_wb_tag",   32'(bus.wb_tag),   32'd1);
    step();

    // Load of untouched 0x03 returns initial content
    drive(1'b1, 1'b0, 8'h03, 8'h00, 2'd3);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0);
    step();
    mid();
    check_eq("init_wb_data", 32'(bus.wb_data), 32'hA6);
    check_eq("init_wb_tag",  32'(bus.wb_tag),  32'd3);
    step();

    // Back-pressure: load 0x40 with wb_ready low for 3 cycles
    bus.wb_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h40, 8'h00, 2'd0);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      mid();
      check_eq("bp_wb_valid",  32'(bus.wb_valid),  32'd1);
      check_eq("bp_wb_data",   32'(bus.wb_data),   32'hE5);
      check_eq("bp_req_ready", 32'(bus.req_ready), 32'd0);
      step();
    end
    bus.wb_ready = 1'b1;
    mid();
    check_eq("bp_release_ready", 32'(bus.req_ready), 32'd1);
    check_eq("bp_release_valid", 32'(bus.wb_valid),  32'd1);
    step();
    mid();
    check_eq("bp_drained", 32'(bus.wb_valid), 32'd0);

    // Overlap: consume result and accept load 0xFF on the same edge
    step();
    drive(1'b1, 1'b0, 8'h20, 8'h00, 2'd1);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0);
    step();
    drive(1'b1, 1'b0, 8'hFF, 8'h00, 2'd2);
    mid();
    check_eq("ov_wb_data",   32'(bus.wb_data),   32'h85);
    check_eq("ov_req_ready", 32'(bus.req_ready), 32'd1);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0);
    mid();
    check_eq("ov_acc_valid", 32'(bus.wb_valid), 32'd0);
    check_eq("ov_acc_addr",  32'(bus.mem_addr), 32'hFF);
    step();
    mid();
    check_eq("ov_wb_valid2", 32'(bus.wb_valid), 32'd1);
    check_eq("ov_wb_data2",  32'(bus.wb_data),  32'h5A);
    check_eq("ov_wb_tag2",   32'(bus.wb_tag),   32'd2);
    step();

    // Reset during the ACCESS cycle of store 0xAA @ 0x10
    drive(1'b1, 1'b1, 8'h10, 8'hAA, 2'd0);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0);
    mid();
    check_eq("rs_we_before", 32'(bus.mem_we), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("rs_mem_we",    32'(bus.mem_we),    32'd0);
    check_eq("rs_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rs_mem_addr",  32'(bus.mem_addr),  32'd0);
    check_eq("rs_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check_eq("rs_wb_valid",  32'(bus.wb_valid),  32'd0);
    check_eq("rs_wb_data",   32'(bus.wb_data),   32'd0);
    check_eq("rs_wb_tag",    32'(bus.wb_tag),    32'd0);
    step();
    rst = 1'b0;
    mid();
    check_eq("rs_ready_after", 32'(bus.req_ready), 32'd1);
    check_eq("rs_mem_kept",    32'(mem_model[8'h10]), 32'hB5);
    step();
    drive(1'b1, 1'b0, 8'h10, 8'h00, 2'd0);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0);
    step();
    mid();
    check_eq("rs_old_value", 32'(bus.wb_data), 32'hB5);
    step();

`ifdef MEM_STAGE_STATS_EN
    // Counters: 3 stores then 2 loads, after a clean reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b1, 1'b1, 8'h60, 8'h01, 2'd0);
    step();
    drive(1'b1, 1'b1, 8'h61, 8'h02, 2'd0);
    step();
    drive(1'b1, 1'b1, 8'h62, 8'h03, 2'd0);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0);
    step();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 8'h60, 8'h00, 2'd0);
      step();
      drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0);
      step();
      step();
    end
    mid();
    check_eq("stat_st_count", 32'(st_count), 32'd3);
    check_eq("stat_ld_count", 32'(ld_count), 32'd2);
    rst = 1'b1;
    #1;
    check_eq("stat_st_rst", 32'(st_count), 32'd0);
    check_eq("stat_ld_rst", 32'(ld_count), 32'd0);
    step();
    rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
